// File: rtl/pc_fetch_stage.sv
// pc_fetch_stage: instruction-fetch front end.
// Owns the PC register and runs a four-state fetch sequencer
// (IDLE -> REQ -> WAIT -> HOLD -> REQ ...). The sequential next PC comes from an
// external incrementer (pc_plus4_in = pc_out + 4). Jump/branch redirects replace
// the PC, and a flag marks any in-flight fetch as stale.
// Optional feature: define FETCH_ALIGN_CHECK_EN to add the sticky misalign_err
// output. Redirects to non-word-aligned targets are then reported and ignored.
// dbg_state exposes the sequencer state so that checkers can bind to it.
//
// Handshakes:
//   imem_req/imem_addr : imem_req is a one-cycle pulse, and imem_addr == pc_out
//                        while it is high. At most one request is outstanding.
//                        imem_rvalid qualifies imem_rdata, and the state machine
//                        samples it only in WAIT.
//   if_valid/id_ready  : a transfer happens on a cycle where if_valid && id_ready.
//                        The payload (if_instr, if_pc, if_pc_plus4) does not
//                        change while if_valid is high and the transfer is pending.
module pc_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc_out,
    input  logic [31:0] pc_plus4_in,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    input  logic        id_ready,
`ifdef FETCH_ALIGN_CHECK_EN
    output logic        misalign_err,
`endif
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        kill_q, kill_d;
    logic        imem_req_q, imem_req_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_pc_plus4_q, if_pc_plus4_d;

    logic        redirect_req;
    logic [31:0] redirect_tgt;
    logic        redirect;

`ifdef FETCH_ALIGN_CHECK_EN
    logic        misalign_hit;
    logic        misalign_err_q, misalign_err_d;
`endif

    // Redirect decode: jump has priority over branch, and redirects are ignored in IDLE.
    always_comb begin
        redirect_req = jump | branch_taken;
        redirect_tgt = jump ? jump_target : branch_target;
`ifdef FETCH_ALIGN_CHECK_EN
        misalign_hit   = (state_q != S_IDLE) && redirect_req && (redirect_tgt[1:0] != 2'b00);
        redirect       = (state_q != S_IDLE) && redirect_req && !misalign_hit;
        misalign_err_d = misalign_err_q | misalign_hit;
`else
        redirect       = (state_q != S_IDLE) && redirect_req;
`endif
    end

    // Next-state and next-output logic for the fetch sequencer.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        kill_d        = kill_q;
        if_valid_d    = if_valid_q;
        if_instr_d    = if_instr_q;
        if_pc_d       = if_pc_q;
        if_pc_plus4_d = if_pc_plus4_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                state_d = S_WAIT;
                if (redirect) begin
                    // The request going out this cycle is for the old PC.
                    pc_d   = redirect_tgt;
                    kill_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    pc_d = redirect_tgt;
                end
                if (imem_rvalid) begin
                    if (kill_q || redirect) begin
                        // This response belongs to a stale request, so drop it and refetch.
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        if_instr_d    = imem_rdata;
                        if_pc_d       = pc_q;
                        if_pc_plus4_d = pc_plus4_in;
                        if_valid_d    = 1'b1;
                        state_d       = S_HOLD;
                    end
                end else if (redirect) begin
                    kill_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    // The redirect target takes priority over the sequential PC, even if decode accepts this cycle.
                    pc_d       = redirect_tgt;
                    if_valid_d = 1'b0;
                    state_d    = S_REQ;
                end else if (id_ready) begin
                    pc_d       = pc_plus4_in;
                    if_valid_d = 1'b0;
                    state_d    = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        imem_req_d = (state_d == S_REQ);
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            kill_q        <= 1'b0;
            imem_req_q    <= 1'b0;
            if_valid_q    <= 1'b0;
            if_instr_q    <= 32'h0;
            if_pc_q       <= 32'h0;
            if_pc_plus4_q <= 32'h0;
`ifdef FETCH_ALIGN_CHECK_EN
            misalign_err_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            kill_q        <= kill_d;
            imem_req_q    <= imem_req_d;
            if_valid_q    <= if_valid_d;
            if_instr_q    <= if_instr_d;
            if_pc_q       <= if_pc_d;
            if_pc_plus4_q <= if_pc_plus4_d;
`ifdef FETCH_ALIGN_CHECK_EN
            misalign_err_q <= misalign_err_d;
`endif
        end
    end

    assign pc_out      = pc_q;
    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign if_valid    = if_valid_q;
    assign if_instr    = if_instr_q;
    assign if_pc       = if_pc_q;
    assign if_pc_plus4 = if_pc_plus4_q;
    assign dbg_state   = state_q;
`ifdef FETCH_ALIGN_CHECK_EN
    assign misalign_err = misalign_err_q;
`endif

endmodule

// File: tb/tb_pc_fetch_stage.sv
// tb_pc_fetch_stage: self-checking bench for pc_fetch_stage.
// The bench provides an external PC+4 incrementer and a memory model with variable
// latency. The reference model is the architectural program flow: the next fetch
// address is the previous PC + 4, or the redirect target. Each delivered
// instruction is the memory word at its PC.
module tb_pc_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4_in;
    logic        jump = 1'b0;
    logic [31:0] jump_target = 32'h0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        id_ready = 1'b1;
    logic [1:0]  dbg_state;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        misalign_err;
`endif

    initial forever #5 clk = ~clk;

    pc_fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .reset        (reset),
        .pc_out       (pc_out),
        .pc_plus4_in  (pc_plus4_in),
        .jump         (jump),
        .jump_target  (jump_target),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .if_valid     (if_valid),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .if_pc_plus4  (if_pc_plus4),
        .id_ready     (id_ready),
`ifdef FETCH_ALIGN_CHECK_EN
        .misalign_err (misalign_err),
`endif
        .dbg_state    (dbg_state)
    );

    // External incrementer
    assign pc_plus4_in = pc_out + 32'd4;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- memory model ----------------
    int          mem_lat = 1;
    bit          inject_rv = 1'b0;
    bit          pend = 1'b0;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = 32'h0;
    logic [31:0] mem_salt = 32'h1234_5678;
    logic [31:0] mem_ovr [logic [31:0]];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_ovr.exists(a)) return mem_ovr[a];
        return (a * 32'h9E37_79B1) ^ mem_salt;
    endfunction

    always @(posedge clk) begin
        imem_rvalid <= 1'b0;
        imem_rdata  <= 32'hDEAD_BEEF;
        if (reset) begin
            pend = 1'b0;
        end else if (imem_req) begin
            pend      = 1'b1;
            pend_addr = imem_addr;
            pend_cnt  = mem_lat;
        end
        if (pend) begin
            pend_cnt = pend_cnt - 1;
            if (pend_cnt <= 0) begin
                pend        = 1'b0;
                imem_rvalid <= 1'b1;
                imem_rdata  <= mem_word(pend_addr);
            end
        end
        if (inject_rv) begin
            imem_rvalid <= 1'b1;
            imem_rdata  <= 32'hBAD0_0BAD;
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        jump = 1'b0;
        branch_taken = 1'b0;
        id_ready = 1'b1;
        inject_rv = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        exp_pc = RESET_PC;
        exp_q.delete();
    endtask

    task automatic wait_req(output bit got, output bit saw_valid);
        got = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (imem_req === 1'b1) begin
                got = 1'b1;
                break;
            end
            if (if_valid === 1'b1) saw_valid = 1'b1;
            tick();
        end
    endtask

    task automatic wait_valid(output bit got);
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (if_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        checks++; if (pc_out !== RESET_PC) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc_out, RESET_PC); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_if_valid: got %b expected 0", if_valid); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_imem_req: got %b expected 0", imem_req); end
        checks++; if ({if_instr, if_pc, if_pc_plus4} !== 96'h0) begin errors++; $display("FAIL reset_payload: got %h/%h/%h expected 0", if_instr, if_pc, if_pc_plus4); end
        // One IDLE cycle after reset is released, then a request is issued
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin errors++; $display("FAIL first_req: got req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, RESET_PC); end
    endtask

    task automatic test_sequential();
        bit got, sv;
        int last_req = 0;
        mem_lat = 1;
        id_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_req(got, sv);
            checks++; if (!got || imem_addr !== exp_pc) begin errors++; $display("FAIL seq_req_addr: got %h expected %h", imem_addr, exp_pc); end
            // With a single-cycle memory, the sequence is REQ, WAIT, HOLD(accept), then the next REQ.
            if (k > 0) begin
                checks++; if (cyc - last_req != 3) begin errors++; $display("FAIL seq_req_spacing: got %0d expected 3", cyc - last_req); end
            end
            last_req = cyc;
            tick();
            wait_valid(got);
            checks++; if (!got || if_pc !== exp_pc) begin errors++; $display("FAIL seq_if_pc: got %h expected %h", if_pc, exp_pc); end
            checks++; if (if_pc_plus4 !== exp_pc + 32'd4) begin errors++; $display("FAIL seq_if_pc_plus4: got %h expected %h", if_pc_plus4, exp_pc + 32'd4); end
            checks++; if (if_instr !== mem_word(exp_pc)) begin errors++; $display("FAIL seq_if_instr: got %h expected %h", if_instr, mem_word(exp_pc)); end
            exp_pc += 32'd4;
            tick();
        end
    endtask

    task automatic test_hold_stall();
        bit got, sv;
        do_reset();
        mem_lat = 1;
        mem_ovr[RESET_PC] = 32'h2002_0005;
        id_ready = 1'b0;
        wait_req(got, sv);
        tick();
        wait_valid(got);
        checks++; if (!got || if_instr !== 32'h2002_0005) begin errors++; $display("FAIL stall_instr: got %h expected 20020005", if_instr); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (if_valid !== 1'b1 || if_instr !== 32'h2002_0005 || if_pc !== RESET_PC || if_pc_plus4 !== RESET_PC + 32'd4 || imem_req !== 1'b0) begin
                errors++;
                $display("FAIL stall_stable: got valid=%b instr=%h pc=%h req=%b expected valid=1 instr=20020005 pc=%h req=0", if_valid, if_instr, if_pc, imem_req, RESET_PC);
            end
        end
        id_ready = 1'b1;
        tick();
        checks++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== RESET_PC + 32'd4) begin errors++; $display("FAIL stall_release: got valid=%b req=%b addr=%h expected 0/1/%h", if_valid, imem_req, imem_addr, RESET_PC + 32'd4); end
        mem_ovr.delete(RESET_PC);
        exp_pc = RESET_PC + 32'd4;
    endtask

    task automatic test_redirect();
        bit got, sv;
        do_reset();
        mem_lat = 1;
        id_ready = 1'b1;
        // Deliver 0x0 and 0x4 normally
        for (int k = 0; k < 2; k++) begin
            wait_req(got, sv);
            tick();
            wait_valid(got);
            checks++; if (!got || if_pc !== exp_pc) begin errors++; $display("FAIL redir_pre_pc: got %h expected %h", if_pc, exp_pc); end
            exp_pc += 32'd4;
            tick();
        end
        // Redirect during REQ for 0x8
        wait_req(got, sv);
        checks++; if (!got || imem_addr !== 32'h8) begin errors++; $display("FAIL redir_req_addr8: got %h expected 00000008", imem_addr); end
        jump = 1'b1; jump_target = 32'h0000_0100;
        tick();
        jump = 1'b0; jump_target = 32'h0;
        wait_req(got, sv);
        checks++; if (!got || sv || imem_addr !== 32'h100) begin errors++; $display("FAIL redir_req_next: got addr=%h stale_valid=%b expected addr=00000100 stale_valid=0", imem_addr, sv); end
        tick();
        wait_valid(got);
        checks++; if (!got || if_pc !== 32'h100 || if_instr !== mem_word(32'h100)) begin errors++; $display("FAIL redir_req_deliver: got pc=%h instr=%h expected 00000100/%h", if_pc, if_instr, mem_word(32'h100)); end
        tick();
        // Redirect during WAIT before the response arrives
        mem_lat = 3;
        wait_req(got, sv);
        checks++; if (!got || imem_addr !== 32'h104) begin errors++; $display("FAIL redir_wait_addr: got %h expected 00000104", imem_addr); end
        tick();
        branch_taken = 1'b1; branch_target = 32'h0000_0180;
        tick();
        branch_taken = 1'b0; branch_target = 32'h0;
        wait_req(got, sv);
        checks++; if (!got || sv || imem_addr !== 32'h180) begin errors++; $display("FAIL redir_wait_next: got addr=%h stale_valid=%b expected 00000180/0", imem_addr, sv); end
        tick();
        wait_valid(got);
        checks++; if (!got || if_pc !== 32'h180 || if_instr !== mem_word(32'h180)) begin errors++; $display("FAIL redir_wait_deliver: got pc=%h instr=%h expected 00000180/%h", if_pc, if_instr, mem_word(32'h180)); end
        tick();
        // Redirect in the same cycle that the response arrives
        mem_lat = 2;
        wait_req(got, sv);
        tick();
        tick();
        jump = 1'b1; jump_target = 32'h0000_01C0;
        tick();
        jump = 1'b0; jump_target = 32'h0;
        checks++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h1C0) begin errors++; $display("FAIL redir_rvalid_same: got valid=%b req=%b addr=%h expected 0/1/000001c0", if_valid, imem_req, imem_addr); end
        tick();
        wait_valid(got);
        checks++; if (!got || if_pc !== 32'h1C0) begin errors++; $display("FAIL redir_rvalid_deliver: got %h expected 000001c0", if_pc); end
        exp_pc = 32'h1C4;
        tick();
    endtask

    task automatic test_jump_branch_hold();
        bit got, sv;
        mem_lat = 1;
        wait_req(got, sv);
        tick();
        id_ready = 1'b0;
        wait_valid(got);
        checks++; if (!got || if_pc !== exp_pc) begin errors++; $display("FAIL hold_pre_pc: got %h expected %h", if_pc, exp_pc); end
        jump = 1'b1; jump_target = 32'h0000_0200;
        branch_taken = 1'b1; branch_target = 32'h0000_0300;
        tick();
        jump = 1'b0; branch_taken = 1'b0;
        checks++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("FAIL hold_jump_prio: got valid=%b req=%b addr=%h expected 0/1/00000200", if_valid, imem_req, imem_addr); end
        id_ready = 1'b1;
        tick();
        wait_valid(got);
        checks++; if (!got || if_pc !== 32'h200) begin errors++; $display("FAIL hold_deliver_200: got %h expected 00000200", if_pc); end
        // A redirect in HOLD wins over the PC update from an accepted instruction
        branch_taken = 1'b1; branch_target = 32'h0000_0340;
        tick();
        branch_taken = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h340) begin errors++; $display("FAIL hold_redir_accept: got req=%b addr=%h expected 1/00000340", imem_req, imem_addr); end
    endtask

    task automatic test_wrap();
        bit got, sv;
        jump = 1'b1; jump_target = 32'hFFFF_FFFC;
        tick();
        jump = 1'b0; jump_target = 32'h0;
        wait_req(got, sv);
        checks++; if (!got || imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req: got %h expected fffffffc", imem_addr); end
        tick();
        wait_valid(got);
        checks++; if (!got || if_pc !== 32'hFFFF_FFFC || if_pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_payload: got %h/%h expected fffffffc/00000000", if_pc, if_pc_plus4); end
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_next_addr: got req=%b addr=%h expected 1/00000000", imem_req, imem_addr); end
    endtask

    task automatic test_reset_in_wait();
        bit got, sv;
        mem_lat = 4;
        jump = 1'b1; jump_target = 32'h0000_5A50;
        tick();
        jump = 1'b0; jump_target = 32'h0;
        wait_req(got, sv);
        checks++; if (!got || imem_addr !== 32'h5A50) begin errors++; $display("FAIL rstw_req: got %h expected 00005a50", imem_addr); end
        tick();
        reset = 1'b1;
        inject_rv = 1'b1;
        tick();
        inject_rv = 1'b0;
        checks++; if (pc_out !== RESET_PC || if_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL rstw_state: got pc=%h valid=%b req=%b expected %h/0/0", pc_out, if_valid, imem_req, RESET_PC); end
        tick();
        reset = 1'b0;
        inject_rv = 1'b1;
        tick();
        inject_rv = 1'b0;
        wait_req(got, sv);
        checks++; if (!got || sv || imem_addr !== RESET_PC) begin errors++; $display("FAIL rstw_first_req: got addr=%h stale_valid=%b expected %h/0", imem_addr, sv, RESET_PC); end
        tick();
        wait_valid(got);
        checks++; if (!got || if_instr !== mem_word(RESET_PC) || if_pc !== RESET_PC) begin errors++; $display("FAIL rstw_late_rvalid: got instr=%h pc=%h expected %h/%h", if_instr, if_pc, mem_word(RESET_PC), RESET_PC); end
        tick();
    endtask

    task automatic test_random();
        bit got, sv;
        logic [31:0] exp_addr;
        logic [31:0] jt, bt;
        bit use_j, use_b;
        int stall;
        mem_salt = $urandom;
        do_reset();
        id_ready = 1'b0;
        exp_q.push_back(exp_pc);
        for (int t = 0; t < 40; t++) begin
            wait_req(got, sv);
            exp_addr = exp_q.pop_front();
            checks++; if (!got || sv || imem_addr !== exp_addr) begin errors++; $display("FAIL rand_req[%0d]: got addr=%h stale_valid=%b expected %h/0", t, imem_addr, sv, exp_addr); end
            mem_lat = $urandom_range(1, 4);
            jt = $urandom & 32'hFFFF_FFFC;
            bt = $urandom & 32'hFFFF_FFFC;
            use_j = $urandom_range(0, 1);
            use_b = use_j ? 1'($urandom_range(0, 1)) : 1'b1;
            if ($urandom_range(0, 9) < 2) begin
                // Redirect while the request is being issued, so no delivery is expected
                jump = use_j; jump_target = jt;
                branch_taken = use_b; branch_target = bt;
                exp_pc = use_j ? jt : bt;
                tick();
                jump = 1'b0; branch_taken = 1'b0;
            end else begin
                tick();
                wait_valid(got);
                checks++; if (!got || if_pc !== exp_pc || if_pc_plus4 !== exp_pc + 32'd4 || if_instr !== mem_word(exp_pc)) begin
                    errors++; $display("FAIL rand_deliver[%0d]: got %h/%h/%h expected %h/%h/%h", t, if_pc, if_pc_plus4, if_instr, exp_pc, exp_pc + 32'd4, mem_word(exp_pc));
                end
                stall = $urandom_range(0, 3);
                repeat (stall) tick();
                checks++; if (if_valid !== 1'b1 || if_pc !== exp_pc) begin errors++; $display("FAIL rand_stall[%0d]: got valid=%b pc=%h expected 1/%h", t, if_valid, if_pc, exp_pc); end
                if ($urandom_range(0, 3) == 0) begin
                    jump = use_j; jump_target = jt;
                    branch_taken = use_b; branch_target = bt;
                    id_ready = $urandom_range(0, 1);
                    exp_pc = use_j ? jt : bt;
                end else begin
                    id_ready = 1'b1;
                    exp_pc += 32'd4;
                end
                tick();
                jump = 1'b0; branch_taken = 1'b0; id_ready = 1'b0;
            end
            exp_q.push_back(exp_pc);
        end
        id_ready = 1'b1;
    endtask

`ifdef FETCH_ALIGN_CHECK_EN
    task automatic test_misalign();
        bit got, sv;
        do_reset();
        mem_lat = 1;
        checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL mis_reset: got %b expected 0", misalign_err); end
        wait_req(got, sv);
        tick();
        wait_valid(got);
        branch_taken = 1'b1; branch_target = 32'h0000_0042;
        tick();
        branch_taken = 1'b0;
        checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL mis_set: got %b expected 1", misalign_err); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC + 32'd4) begin errors++; $display("FAIL mis_sequential: got req=%b addr=%h expected 1/%h", imem_req, imem_addr, RESET_PC + 32'd4); end
        tick();
        wait_valid(got);
        tick();
        checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL mis_sticky: got %b expected 1", misalign_err); end
        do_reset();
        checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL mis_clear: got %b expected 0", misalign_err); end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_sequential();
        test_hold_stall();
        test_redirect();
        test_jump_branch_hold();
        test_wrap();
        test_reset_in_wait();
        test_random();
`ifdef FETCH_ALIGN_CHECK_EN
        test_misalign();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
